decode_stage: RTL and testbench

- ID stage of the 5-stage MIPS pipeline.
- Decodes the IF/ID instruction through the main control unit and reads rs/rt from a 32x32 register file.
- Sign-extends the 16-bit immediate and registers everything into the ID/EX pipeline register.
- The register file write port is driven by the MEM/WB stage.

---
 rtl/decode_stage.sv | 107 ++++++++++
 tb/tb_decode_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ID stage of the 5-stage MIPS pipeline: main control decode, 32x32 register file with
// write-through bypass, immediate sign extension and the ID/EX pipeline register.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IF_ID_instruction,
  input  logic [31:0] IF_ID_npc,
  input  logic [4:0]  MEM_WB_rd,
  input  logic        MEM_WB_reg_write,
  input  logic [31:0] WB_mux5_write_data,
  output logic [1:0]  wb_ctl_out,
  output logic [2:0]  m_ctl_out,
  output logic        reg_dst,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [31:0] npc_out,
  output logic [31:0] r_data1_out,
  output logic [31:0] r_data2_out,
  output logic [31:0] sign_extend_out,
  output logic [4:0]  instruction_out_2016,
  output logic [4:0]  instruction_out_1511
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [3:0]  ex_ctl;
  logic [2:0]  m_ctl;
  logic [1:0]  wb_ctl;
  logic [31:0] r_data1, r_data2, sign_ext;
  logic        wr_en;
  logic [31:0] regs_q [32];

  assign opcode = IF_ID_instruction[31:26];
  assign rs     = IF_ID_instruction[25:21];
  assign rt     = IF_ID_instruction[20:16];
  assign rd     = IF_ID_instruction[15:11];

  // Control bundles: ex_ctl = {reg_dst, alu_op[1:0], alu_src}
  always_comb begin
    ex_ctl = 4'b0000;
    m_ctl  = 3'b000;
    wb_ctl = 2'b00;
    case (opcode)
      OpRtype: begin ex_ctl = 4'b1100; m_ctl = 3'b000; wb_ctl = 2'b10; end
      OpLw:    begin ex_ctl = 4'b0001; m_ctl = 3'b010; wb_ctl = 2'b11; end
      OpSw:    begin ex_ctl = 4'b0001; m_ctl = 3'b001; wb_ctl = 2'b00; end
      OpBeq:   begin ex_ctl = 4'b0010; m_ctl = 3'b100; wb_ctl = 2'b00; end
      default: begin ex_ctl = 4'b0000; m_ctl = 3'b000; wb_ctl = 2'b00; end
    endcase
  end

  assign wr_en = MEM_WB_reg_write && (MEM_WB_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[MEM_WB_rd] <= WB_mux5_write_data;
    end
  end

  // Same-cycle write-back is forwarded so ID/EX captures the value being written.
  always_comb begin
    if (rs == 5'd0)                       r_data1 = '0;
    else if (wr_en && MEM_WB_rd == rs)    r_data1 = WB_mux5_write_data;
    else                                  r_data1 = regs_q[rs];
    if (rt == 5'd0)                       r_data2 = '0;
    else if (wr_en && MEM_WB_rd == rt)    r_data2 = WB_mux5_write_data;
    else                                  r_data2 = regs_q[rt];
  end

  assign sign_ext = {{16{IF_ID_instruction[15]}}, IF_ID_instruction[15:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_ctl_out           <= '0;
      m_ctl_out            <= '0;
      reg_dst              <= 1'b0;
      alu_op               <= '0;
      alu_src              <= 1'b0;
      npc_out              <= '0;
      r_data1_out          <= '0;
      r_data2_out          <= '0;
      sign_extend_out      <= '0;
      instruction_out_2016 <= '0;
      instruction_out_1511 <= '0;
    end else begin
      wb_ctl_out           <= wb_ctl;
      m_ctl_out            <= m_ctl;
      reg_dst              <= ex_ctl[3];
      alu_op               <= ex_ctl[2:1];
      alu_src              <= ex_ctl[0];
      npc_out              <= IF_ID_npc;
      r_data1_out          <= r_data1;
      r_data2_out          <= r_data2;
      sign_extend_out      <= sign_ext;
      instruction_out_2016 <= rt;
      instruction_out_1511 <= rd;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases with literal expectations plus randomized traffic
// checked every cycle against a behavioural model of the register file and decoder.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IF_ID_instruction = '0;
  logic [31:0] IF_ID_npc = '0;
  logic [4:0]  MEM_WB_rd = '0;
  logic        MEM_WB_reg_write = 1'b0;
  logic [31:0] WB_mux5_write_data = '0;
  logic [1:0]  wb_ctl_out;
  logic [2:0]  m_ctl_out;
  logic        reg_dst, alu_src;
  logic [1:0]  alu_op;
  logic [31:0] npc_out, r_data1_out, r_data2_out, sign_extend_out;
  logic [4:0]  instruction_out_2016, instruction_out_1511;

  int errors = 0;
  int checks = 0;

  decode_stage dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .IF_ID_instruction    (IF_ID_instruction),
    .IF_ID_npc            (IF_ID_npc),
    .MEM_WB_rd            (MEM_WB_rd),
    .MEM_WB_reg_write     (MEM_WB_reg_write),
    .WB_mux5_write_data   (WB_mux5_write_data),
    .wb_ctl_out           (wb_ctl_out),
    .m_ctl_out            (m_ctl_out),
    .reg_dst              (reg_dst),
    .alu_src              (alu_src),
    .alu_op               (alu_op),
    .npc_out              (npc_out),
    .r_data1_out          (r_data1_out),
    .r_data2_out          (r_data2_out),
    .sign_extend_out      (sign_extend_out),
    .instruction_out_2016 (instruction_out_2016),
    .instruction_out_1511 (instruction_out_1511)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {wb[1:0], m[2:0], reg_dst, alu_op[1:0], alu_src}
  function automatic logic [8:0] ctl_of(input logic [5:0] op);
    case (op)
      6'h00:   return {2'b10, 3'b000, 1'b1, 2'b10, 1'b0};
      6'h23:   return {2'b11, 3'b010, 1'b0, 2'b00, 1'b1};
      6'h2B:   return {2'b00, 3'b001, 1'b0, 2'b00, 1'b1};
      6'h04:   return {2'b00, 3'b100, 1'b0, 2'b01, 1'b0};
      default: return 9'd0;
    endcase
  endfunction

  // Behavioural model: architectural register array plus expected ID/EX contents.
  logic [31:0] mregs [32];
  logic [8:0]  e_ctl;
  logic [31:0] e_npc, e_d1, e_d2, e_se;
  logic [4:0]  e_rt, e_rd;
  bit          seen_reset = 0;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (MEM_WB_reg_write && MEM_WB_rd == a) return WB_mux5_write_data;
    return mregs[a];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      seen_reset = 1;
      e_ctl = 0; e_npc = 0; e_d1 = 0; e_d2 = 0; e_se = 0; e_rt = 0; e_rd = 0;
      for (int i = 0; i < 32; i++) mregs[i] = 0;
    end else begin
      e_ctl = ctl_of(IF_ID_instruction[31:26]);
      e_npc = IF_ID_npc;
      e_d1  = model_read(IF_ID_instruction[25:21]);
      e_d2  = model_read(IF_ID_instruction[20:16]);
      e_se  = 32'($signed(IF_ID_instruction[15:0]));
      e_rt  = IF_ID_instruction[20:16];
      e_rd  = IF_ID_instruction[15:11];
      if (MEM_WB_reg_write && MEM_WB_rd != 0) mregs[MEM_WB_rd] = WB_mux5_write_data;
    end
  end

  always @(negedge clk) begin
    if (seen_reset) begin
      chk("ctl", 32'({wb_ctl_out, m_ctl_out, reg_dst, alu_op, alu_src}), 32'(e_ctl));
      chk("npc", npc_out, e_npc);
      chk("rdata1", r_data1_out, e_d1);
      chk("rdata2", r_data2_out, e_d2);
      chk("sext", sign_extend_out, e_se);
      chk("rt", 32'(instruction_out_2016), 32'(e_rt));
      chk("rd", 32'(instruction_out_1511), 32'(e_rd));
    end
  end

  // Drive one cycle of inputs at negedge, then sample just after the capturing edge.
  task automatic cyc(input logic [31:0] ins, input logic [31:0] npc, input logic we,
                     input logic [4:0] wrd, input logic [31:0] wd, input logic rn);
    @(negedge clk);
    IF_ID_instruction  = ins;
    IF_ID_npc          = npc;
    MEM_WB_reg_write   = we;
    MEM_WB_rd          = wrd;
    WB_mux5_write_data = wd;
    rst_n              = rn;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] Bubble = 32'hFC00_0000;
  localparam logic [31:0] AddI   = 32'h0109_5020;

  initial begin
    logic [31:0] r, ins;
    logic [5:0]  op;
    cyc($urandom(), $urandom(), 1'b1, 5'd3, $urandom(), 1'b0);
    cyc($urandom(), $urandom(), 1'b1, 5'd4, $urandom(), 1'b0);
    chk("rst_wb", 32'(wb_ctl_out), 0);
    chk("rst_m", 32'(m_ctl_out), 0);
    chk("rst_npc", npc_out, 0);
    chk("rst_d1", r_data1_out, 0);
    chk("rst_se", sign_extend_out, 0);
    for (int i = 1; i < 32; i++) begin
      cyc({6'd0, 5'(i), 5'(i), 16'h0}, 32'(i), 1'b0, 5'd0, 0, 1'b1);
      chk("clr_reg", r_data1_out, 0);
    end

    cyc(Bubble, 0, 1'b1, 5'd8, 32'hAA, 1'b1);
    cyc(Bubble, 0, 1'b1, 5'd9, 32'h55, 1'b1);
    cyc(AddI, 32'h4, 1'b0, 5'd0, 0, 1'b1);
    chk("add_ctl", 32'({wb_ctl_out, m_ctl_out, reg_dst, alu_op, alu_src}), 32'b10_000_1_10_0);
    chk("add_npc", npc_out, 32'h4);
    chk("add_d1", r_data1_out, 32'hAA);
    chk("add_d2", r_data2_out, 32'h55);
    chk("add_rt", 32'(instruction_out_2016), 32'd9);
    chk("add_rd", 32'(instruction_out_1511), 32'd10);
    chk("add_se", sign_extend_out, 32'h0000_5020);

    cyc(32'h8D09_FFFC, 32'h8, 1'b0, 5'd0, 0, 1'b1);
    chk("lw_ctl", 32'({wb_ctl_out, m_ctl_out, reg_dst, alu_op, alu_src}), 32'b11_010_0_00_1);
    chk("lw_se", sign_extend_out, 32'hFFFF_FFFC);
    cyc(32'hAD09_0008, 32'hC, 1'b0, 5'd0, 0, 1'b1);
    chk("sw_ctl", 32'({wb_ctl_out, m_ctl_out, reg_dst, alu_op, alu_src}), 32'b00_001_0_00_1);
    cyc(32'h1109_0003, 32'h10, 1'b0, 5'd0, 0, 1'b1);
    chk("beq_ctl", 32'({wb_ctl_out, m_ctl_out, reg_dst, alu_op, alu_src}), 32'b00_100_0_01_0);
    chk("beq_se", sign_extend_out, 32'h3);

    cyc(AddI, 32'h14, 1'b1, 5'd8, 32'h1234_5678, 1'b1);
    chk("bypass_d1", r_data1_out, 32'h1234_5678);
    chk("bypass_d2", r_data2_out, 32'h55);
    cyc(Bubble, 32'h18, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    cyc(32'h0009_5020, 32'h1C, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    chk("r0_read", r_data1_out, 0);

    cyc(Bubble, 32'h20, 1'b0, 5'd0, 0, 1'b1);
    chk("unk_ctl", 32'({wb_ctl_out, m_ctl_out, reg_dst, alu_op, alu_src}), 0);

    cyc(AddI, 32'h24, 1'b0, 5'd0, 0, 1'b1);
    chk("pre_rst_npc", npc_out, 32'h24);
    cyc(32'h8D09_FFFC, 32'h28, 1'b1, 5'd9, 32'hDEAD, 1'b0);
    chk("mid_rst_npc", npc_out, 0);
    chk("mid_rst_ctl", 32'({wb_ctl_out, m_ctl_out, reg_dst, alu_op, alu_src}), 0);
    chk("mid_rst_se", sign_extend_out, 0);
    cyc(AddI, 32'h2C, 1'b0, 5'd0, 0, 1'b1);
    chk("post_rst_npc", npc_out, 32'h2C);
    chk("post_rst_d1", r_data1_out, 0);
    chk("post_rst_d2", r_data2_out, 0);
    chk("post_rst_ctl", 32'({wb_ctl_out, m_ctl_out, reg_dst, alu_op, alu_src}),
        32'b10_000_1_10_0);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 4))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: begin r = $urandom(); op = r[5:0]; end
      endcase
      r   = $urandom();
      ins = {op, r[25:0]};
      r   = $urandom();
      cyc(ins, $urandom(), r[0] | r[1], ($urandom_range(0, 3) == 0) ? ins[25:21] : 5'(r[8:4]),
          $urandom(), ($urandom_range(0, 63) != 0));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
